// File: rtl/onn_run_sequencer.sv
// Run sequencer for the 15-neuron oscillator array: serial config load, delayed
// nout->nin feedback run, convergence/inconsistency/timeout detection with retry.
//
// state  | meaning
// S_IDLE | waiting for start; result and status flags held
// S_LOAD | shifting the config image into the array, MSB first, load_o high
// S_GAP  | one quiet cycle; feedback pipe preloaded with the initial pattern
// S_RUN  | array running with delayed feedback; steady/incons/timeout watched
// S_DONE | one-cycle done pulse, then back to idle
module onn_run_sequencer #(
   parameter int N_NEUR     = 15,
   parameter int CFG_BITS   = 60,
   parameter int FB_DLY     = 2,
   parameter int SETTLE_MIN = 8,
   parameter int TIMEOUT    = 1024,
   parameter int MAX_RETRY  = 3,
   parameter int CNT_W      = 11
) (
   input  logic                sclk,
   input  logic                re,
   input  logic                start,
   input  logic [CFG_BITS-1:0] cfg_word,
   input  logic [N_NEUR-1:0]   init_pattern,
   output logic                bit_o,
   output logic                load_o,
   output logic [N_NEUR-1:0]   nin_o,
   input  logic [N_NEUR-1:0]   nout_i,
   input  logic                steady_i,
   input  logic                incons_i,
   output logic                busy,
   output logic                done,
   output logic [N_NEUR-1:0]   result,
   output logic                converged,
   output logic                fail_incons,
   output logic                fail_timeout,
   output logic [1:0]          retries
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LP_LOAD_LAST = CNT_W'(CFG_BITS - 1);
   localparam logic [CNT_W-1:0] LP_SETTLE    = CNT_W'(SETTLE_MIN);
   localparam logic [CNT_W-1:0] LP_TMO       = CNT_W'(TIMEOUT);
   localparam logic [1:0]       LP_MAX_RETRY = 2'(MAX_RETRY);

   state_t              r_state;
   state_t              w_state_nx;
   logic [CFG_BITS-1:0] r_cfg_img;
   logic [CFG_BITS-1:0] r_shift;
   logic [N_NEUR-1:0]   r_pat;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_stdy;
   logic [N_NEUR-1:0]   r_fb [FB_DLY];
   logic [N_NEUR-1:0]   r_nin_hold;
   logic [N_NEUR-1:0]   r_result;
   logic                r_conv;
   logic                r_fail_incons;
   logic                r_fail_tmo;
   logic [1:0]          r_retries;

   logic                w_accept;
   logic                w_retry;
   logic                w_fin_incons;
   logic                w_fin_conv;
   logic                w_fin_tmo;
   logic [CNT_W-1:0]    w_tmo_nx;
   logic [CNT_W-1:0]    w_stdy_nx;

   always_comb begin
      w_state_nx   = r_state;
      w_accept     = 1'b0;
      w_retry      = 1'b0;
      w_fin_incons = 1'b0;
      w_fin_conv   = 1'b0;
      w_fin_tmo    = 1'b0;
      w_tmo_nx     = r_cnt + CNT_W'(1);
      w_stdy_nx    = (steady_i && !incons_i) ? r_stdy + CNT_W'(1) : '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept   = 1'b1;
               w_state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            if (r_cnt == LP_LOAD_LAST) w_state_nx = S_GAP;
         end
         S_GAP: w_state_nx = S_RUN;
         S_RUN: begin
            // inconsistency outranks a simultaneous convergence or timeout
            if (incons_i) begin
               if (r_retries < LP_MAX_RETRY) begin
                  w_retry    = 1'b1;
                  w_state_nx = S_LOAD;
               end else begin
                  w_fin_incons = 1'b1;
                  w_state_nx   = S_DONE;
               end
            end else if (w_stdy_nx == LP_SETTLE) begin
               w_fin_conv = 1'b1;
               w_state_nx = S_DONE;
            end else if (w_tmo_nx == LP_TMO) begin
               w_fin_tmo  = 1'b1;
               w_state_nx = S_DONE;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge sclk or posedge re) begin
      if (re) begin
         r_state       <= S_IDLE;
         r_cfg_img     <= '0;
         r_shift       <= '0;
         r_pat         <= '0;
         r_cnt         <= '0;
         r_stdy        <= '0;
         for (int i = 0; i < FB_DLY; i++) r_fb[i] <= '0;
         r_nin_hold    <= '0;
         r_result      <= '0;
         r_conv        <= 1'b0;
         r_fail_incons <= 1'b0;
         r_fail_tmo    <= 1'b0;
         r_retries     <= 2'd0;
      end else begin
         r_state <= w_state_nx;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cfg_img     <= cfg_word;
                  r_shift       <= cfg_word;
                  r_pat         <= init_pattern;
                  r_cnt         <= '0;
                  r_conv        <= 1'b0;
                  r_fail_incons <= 1'b0;
                  r_fail_tmo    <= 1'b0;
                  r_retries     <= 2'd0;
               end
            end
            S_LOAD: begin
               r_shift <= {r_shift[CFG_BITS-2:0], 1'b0};
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            S_GAP: begin
               for (int i = 0; i < FB_DLY; i++) r_fb[i] <= r_pat;
               r_cnt  <= '0;
               r_stdy <= '0;
            end
            S_RUN: begin
               r_fb[0] <= nout_i;
               for (int i = 1; i < FB_DLY; i++) r_fb[i] <= r_fb[i-1];
               r_nin_hold <= r_fb[FB_DLY-1];
               r_cnt      <= w_tmo_nx;
               r_stdy     <= w_stdy_nx;
               if (w_retry) begin
                  r_retries <= r_retries + 2'd1;
                  r_shift   <= r_cfg_img;
                  r_cnt     <= '0;
               end
               if (w_fin_incons) r_fail_incons <= 1'b1;
               if (w_fin_conv)   r_conv        <= 1'b1;
               if (w_fin_tmo)    r_fail_tmo    <= 1'b1;
               if (w_fin_incons || w_fin_conv || w_fin_tmo) r_result <= nout_i;
            end
            default: ;
         endcase
      end
   end

   // nin_o follows the pipe only while running, otherwise it holds the last driven pattern
   assign nin_o        = (r_state == S_RUN) ? r_fb[FB_DLY-1] : r_nin_hold;
   assign bit_o        = (r_state == S_LOAD) ? r_shift[CFG_BITS-1] : 1'b0;
   assign load_o       = (r_state == S_LOAD);
   assign busy         = (r_state != S_IDLE);
   assign done         = (r_state == S_DONE);
   assign result       = r_result;
   assign converged    = r_conv;
   assign fail_incons  = r_fail_incons;
   assign fail_timeout = r_fail_tmo;
   assign retries      = r_retries;

endmodule

// File: tb/tb_onn_run_sequencer.sv
// Directed bench for onn_run_sequencer: a small array model drives RUN inputs,
// expected config bits, nin patterns and completion records are queued and popped.
module tb_onn_run_sequencer;

   localparam int M_CONV   = 0;
   localparam int M_INCONS = 1;
   localparam int M_TMO    = 2;
   localparam int M_TMO7   = 3;
   localparam int M_PRIO   = 4;

   logic        sclk = 1'b0;
   logic        re = 1'b1;
   logic        start = 1'b0;
   logic [59:0] cfg_word = '0;
   logic [14:0] init_pattern = '0;
   logic [14:0] nout_i = '0;
   logic        steady_i = 1'b0;
   logic        incons_i = 1'b0;
   logic        bit_o, load_o, busy, done, converged, fail_incons, fail_timeout;
   logic [14:0] nin_o, result;
   logic [1:0]  retries;

   typedef struct packed {
      logic [14:0] res;
      logic        c;
      logic        fi;
      logic        ft;
      logic [1:0]  r;
   } exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   int          done_cnt = 0;
   int          exp_retries = 0;
   logic [59:0] cur_cfg = '0;
   logic [14:0] hold_pat = '0;
   logic [14:0] last_nin = '0;
   logic        bit_q[$];
   exp_t        res_q[$];

   onn_run_sequencer #(
      .N_NEUR(15), .CFG_BITS(60), .FB_DLY(2), .SETTLE_MIN(8),
      .TIMEOUT(1024), .MAX_RETRY(3), .CNT_W(11)
   ) dut (
      .sclk(sclk), .re(re), .start(start), .cfg_word(cfg_word),
      .init_pattern(init_pattern), .bit_o(bit_o), .load_o(load_o),
      .nin_o(nin_o), .nout_i(nout_i), .steady_i(steady_i), .incons_i(incons_i),
      .busy(busy), .done(done), .result(result), .converged(converged),
      .fail_incons(fail_incons), .fail_timeout(fail_timeout), .retries(retries)
   );

   always #5 sclk = ~sclk;

   always @(posedge sclk) if (done === 1'b1) done_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed run still active, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, 64'({busy, done, load_o, bit_o, converged, fail_incons,
                                 fail_timeout, retries}), 64'd0);
      check({tag, "_nin"}, 64'(nin_o), 64'd0);
      check({tag, "_result"}, 64'(result), 64'd0);
   endtask

   function automatic void model(input int mode, input int k, output logic st,
                                 output logic inc, output logic [14:0] nv);
      st = 1'b0; inc = 1'b0; nv = '0;
      case (mode)
         M_CONV: begin
            st = (k >= 3);
            nv = (k == 1) ? 15'h0111 : (k == 2) ? 15'h0222 : 15'h2AAA;
         end
         M_INCONS: begin
            st  = (k % 2) == 0;
            inc = (k == 5);
            nv  = 15'h1000 + 15'(k);
         end
         M_TMO:  nv = 15'(k);
         M_TMO7: begin
            st = (k % 7) != 0;
            nv = 15'h4000 | 15'(k);
         end
         M_PRIO: begin
            st  = 1'b1;
            inc = (k == 8);
            nv  = 15'h3333;
         end
         default: ;
      endcase
   endfunction

   task automatic push_cfg_bits();
      for (int i = 59; i >= 0; i--) bit_q.push_back(cur_cfg[i]);
   endtask

   task automatic do_start(input logic [59:0] cfg, input logic [14:0] pat);
      start = 1'b1; cfg_word = cfg; init_pattern = pat;
      cur_cfg = cfg; hold_pat = pat; exp_retries = 0;
      push_cfg_bits();
      @(negedge sclk);
      start = 1'b0;
      check("start_accept", 64'({busy, load_o, converged, fail_incons, fail_timeout, retries}),
            64'(7'b1100000));
   endtask

   task automatic load_and_gap(input bit poke_start);
      int   n = 0;
      logic b;
      while (load_o === 1'b1 && n < 100) begin
         b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
         check("load_bit", 64'(bit_o), 64'(b));
         if (poke_start && n == 10) begin
            start = 1'b1; cfg_word = ~cur_cfg; init_pattern = ~hold_pat;
         end else begin
            start = 1'b0;
         end
         n++;
         @(negedge sclk);
      end
      start = 1'b0;
      check("load_len", 64'(n), 64'd60);
      check("gap_outputs", 64'({load_o, bit_o, busy}), 64'(3'b001));
      check("gap_nin_hold", 64'(nin_o), 64'(last_nin));
      @(negedge sclk);
   endtask

   task automatic run_phase(input int mode, output int ev);
      logic [14:0] nq[$];
      logic [14:0] nv, exp_nin;
      logic        st, inc;
      int          sc = 0;
      int          k = 1;
      int          exp_ev;
      bit          fin = 1'b0;
      nq.push_back(hold_pat);
      nq.push_back(hold_pat);
      ev = 0;
      while (!fin && k <= 1100) begin
         model(mode, k, st, inc, nv);
         steady_i = st; incons_i = inc; nout_i = nv;
         exp_nin = nq.pop_front();
         check("nin_feedback", 64'(nin_o), 64'(exp_nin));
         last_nin = exp_nin;
         nq.push_back(nv);
         exp_ev = 0;
         if (inc) begin
            if (exp_retries < 3) begin
               exp_retries++;
               push_cfg_bits();
               exp_ev = 1;
            end else begin
               res_q.push_back('{res: nv, c: 1'b0, fi: 1'b1, ft: 1'b0, r: 2'(exp_retries)});
               exp_ev = 2;
            end
         end else begin
            sc = st ? sc + 1 : 0;
            if (sc == 8) begin
               res_q.push_back('{res: nv, c: 1'b1, fi: 1'b0, ft: 1'b0, r: 2'(exp_retries)});
               exp_ev = 2;
            end else if (k == 1024) begin
               res_q.push_back('{res: nv, c: 1'b0, fi: 1'b0, ft: 1'b1, r: 2'(exp_retries)});
               exp_ev = 2;
            end
         end
         @(negedge sclk);
         case (exp_ev)
            1:       check("retry_reload", 64'(load_o), 64'd1);
            2:       check("done_pulse", 64'(done), 64'd1);
            default: check("run_stay", 64'({done, load_o}), 64'd0);
         endcase
         if (exp_ev != 0) begin
            ev  = exp_ev;
            fin = 1'b1;
         end
         k++;
      end
      steady_i = 1'b0; incons_i = 1'b0;
   endtask

   task automatic check_done();
      exp_t e = '0;
      check("res_avail", 64'(res_q.size() > 0), 64'd1);
      if (res_q.size() > 0) e = res_q.pop_front();
      check("result", 64'(result), 64'(e.res));
      check("status", 64'({converged, fail_incons, fail_timeout, retries}),
            64'({e.c, e.fi, e.ft, e.r}));
      @(negedge sclk);
      check("done_one_cycle", 64'({done, busy}), 64'd0);
      check("status_held", 64'({converged, fail_incons, fail_timeout, retries}),
            64'({e.c, e.fi, e.ft, e.r}));
   endtask

   task automatic do_run(input logic [59:0] cfg, input logic [14:0] pat,
                         input int m0, input int mn, input bit poke);
      int ev = 1;
      int att = 0;
      do_start(cfg, pat);
      while (ev == 1 && att < 8) begin
         load_and_gap(poke && att == 0);
         run_phase((att == 0) ? m0 : mn, ev);
         att++;
      end
      if (ev == 2) check_done();
      else check("run_end", 64'(ev), 64'd2);
   endtask

   initial begin
      repeat (2) @(negedge sclk);
      check_all_zero("reset");
      re = 1'b0;
      @(negedge sclk);
      check("idle_after_reset", 64'({busy, done, load_o}), 64'd0);

      // converge on first try, with an ignored start poked mid-load
      do_run(60'hFFFF_F5FF_F1FF_F5F, 15'h5555, M_CONV, M_CONV, 1'b1);
      // back-to-back start; inconsistent every attempt until retries run out
      do_run(60'h0123_4567_89AB_CDE, 15'h1234, M_INCONS, M_INCONS, 1'b0);
      do_run(60'hA5A5_A5A5_A5A5_A5A, 15'h7FFF, M_TMO, M_TMO, 1'b0);
      do_run(60'h8000_0000_0000_001, 15'h0001, M_TMO7, M_TMO7, 1'b0);
      // incons coincident with the 8th steady cycle forces a retry, then converges
      do_run(60'hC3C3_0F0F_F0F0_3C3, 15'h2468, M_PRIO, M_CONV, 1'b0);

      do_start(60'hDEAD_BEEF_CAFE_123, 15'h0F0F);
      repeat (29) @(negedge sclk);
      check("load30_active", 64'(load_o), 64'd1);
      #2 re = 1'b1;
      #1 check_all_zero("abort_load");
      @(negedge sclk);
      re = 1'b0; bit_q.delete(); last_nin = '0;
      @(negedge sclk);
      check("idle_after_load_abort", 64'({busy, done, load_o}), 64'd0);

      do_start(60'h1357_9BDF_0246_8AC, 15'h0F0F);
      load_and_gap(1'b0);
      nout_i = 15'h7001;
      repeat (20) @(negedge sclk);
      check("run_nin_before_abort", 64'({busy, nin_o}), 64'({1'b1, 15'h7001}));
      #2 re = 1'b1;
      #1 check_all_zero("abort_run");
      @(negedge sclk);
      re = 1'b0; nout_i = '0; bit_q.delete(); res_q.delete(); last_nin = '0;
      @(negedge sclk);
      check("idle_after_run_abort", 64'({busy, done, load_o}), 64'd0);

      do_run(60'hFFFF_F5FF_F1FF_F5F, 15'h5555, M_CONV, M_CONV, 1'b0);
      repeat (3) @(negedge sclk);
      check("done_count", 64'(done_cnt), 64'd6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
